mux_n_reg: RTL
==============

// Module: mux_n_reg
// PURPOSE
//  Parametrised successor to the SISC 3-way 16-bit datapath mux. Selects one of
//  NUM_IN WIDTH-bit sources, by explicit select or round-robin, into a 1-deep
//  registered output stage with valid/ready backpressure. Used where the
//  datapath needs a registered, flow-controlled merge: register-file writeback,
//  multi-source bus feeds.
// PARAMETERS
//  WIDTH   16  data width per source, >=1
//  NUM_IN  3   number of sources, 2..16
//  SEL_W   2   select width = clog2(NUM_IN); derived, do not override
// PORTS
//  clk       in   1             clock; all state updates on rising edge
//  rst       in   1             async reset, active-high
//  in_data   in   NUM_IN*WIDTH  source i at [i*WIDTH +: WIDTH]
//  in_valid  in   NUM_IN        source i offers data
//  in_ready  out  NUM_IN        source i accepted this cycle when also valid
//  sel       in   SEL_W         explicit source select (mode 0)
//  mode      in   1             0 = explicit select, 1 = round-robin
//  out_data  out  WIDTH         registered output data
//  out_valid out  1             out_data is valid
//  out_ready in   1             downstream consumes when out_valid & out_ready
//  out_src   out  SEL_W         index of source held in out_data
// BEHAVIOUR
//  Clock/reset: one clock, clk; rst is asynchronous, active-high.
//  Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1.
//   in_ready is combinational and reads 0 while rst is high.
//  load_en = !out_valid | out_ready. Output ready passes through combinationally
//   to the chosen source. No bubble occurs at full throughput.
//  Mode 0: chosen = sel when sel<NUM_IN, else NUM_IN-1. Out-of-range select
//   defaults to the last source, as in the 3-way mux.
//  Mode 1: chosen = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ...
//   mod NUM_IN. rr_ptr <= chosen only on a transfer. Grants wrap NUM_IN-1 -> 0.
//   With no source valid, nothing is chosen and rr_ptr holds.
//  in_ready[chosen] = load_en; every other in_ready bit = 0.
//   Exactly one in_ready bit, or none, is high.
//  Transfer (in_valid[chosen] & in_ready[chosen]):
//   next edge: out_data <= source data, out_src <= chosen, out_valid <= 1.
//   Latency: 1 cycle from accept to out_valid.
//  Consume without a transfer: out_valid <= 0. out_data and out_src hold their
//   last value.
//  Consume and transfer in the same cycle: the register reloads and out_valid
//   stays 1.
//  Stall (out_valid & !out_ready): out_data, out_src and out_valid hold.
//   Changes on sel, mode or in_data do not affect held data.
//  A mode or sel change takes effect for the selection in the same cycle.
//   rr_ptr is preserved across mode changes.
//  rst mid-stall: the held word is discarded and out_valid drops immediately.
//   The source handshake is not replayed.
//  in_valid on an unchosen source is ignored, and that data is not consumed.
// STRUCTURE
//  Shared package sisc_mux_pkg holds:
//   - MODE_SEL=1'b0 and MODE_RR=1'b1
//   - clog2 function used for SEL_W
//  Sub-module rr_arbiter: NUM_IN-wide request vector in, one-hot grant and
//   index out, with internal pointer and advance-on-accept input. Used only
//   in mode 1; its grant is gated by mode.
//  Top level: select mux, out-of-range clamp, output register, in_ready decode.
// TESTING
//  1 Mode0, NUM_IN=3, sel=1, in_valid=3'b010, data1=16'hBEEF, out_ready=1
//    -> in_ready=3'b010; next cycle out_data=BEEF, out_src=1, out_valid=1.
//  2 Mode0, sel=3 (out of range), in_valid=3'b100, data2=16'h1234
//    -> source 2 accepted; out_data=1234, out_src=2.
//  3 Mode1, all valid every cycle, out_ready=1
//    -> out_src sequence 0,1,2,0,1 with one word per cycle and no bubbles.
//  4 Mode1, out_valid=1 holding 16'hAAAA, out_ready=0 for 3 cycles while
//    sources change -> out_data=AAAA, in_ready=0, rr_ptr unchanged;
//    on out_ready=1 the next grant follows the pointer.
//  5 Mode1, in_valid=3'b101 with rr_ptr=0 -> grant 2, then grant 0
//    (wrap-around); with in_valid=0 for 2 cycles, out_valid drops and
//    rr_ptr holds.
//  6 Assert rst asynchronously mid-stall, between clock edges
//    -> out_valid=0, out_data=0, out_src=0 immediately; in_ready=0 during rst;
//    after release the first RR grant goes to source 0.

Source files
------------

// File: rtl/sisc_mux_pkg.sv
// Shared definitions for the SISC datapath mux family: mode encodings and
// the width helper used to derive select widths.
package sisc_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Ceiling log2, never below 1 so a select port always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < 32'(n)) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_reg_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last accepted
// index, wrapping NUM_IN-1 -> 0; the pointer moves only when a grant is taken.
module rr_arbiter #(
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    localparam int unsigned N = NUM_IN;

    logic [SEL_W-1:0] ptr;
    int unsigned      cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SEL_W'(NUM_IN - 1);
        end else if (advance) begin
            ptr <= idx;
        end
    end

    // Search ptr+1, ptr+2, ... modulo N; the first valid request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) cand = cand - N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && i == cand && req[i]) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered NUM_IN-way merge with explicit or round-robin selection and a
// 1-deep valid/ready output stage.
module mux_n_reg
    import sisc_mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    localparam int unsigned N = NUM_IN;
    localparam int unsigned W = WIDTH;

    logic              rr_mode;
    logic              load_en;
    logic              transfer;
    logic [SEL_W-1:0]  sel_clamp;
    logic [SEL_W-1:0]  chosen;
    logic [NUM_IN-1:0] sel_onehot;
    logic [NUM_IN-1:0] pick_onehot;
    logic [WIDTH-1:0]  src_data;
    logic [NUM_IN-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;

    assign rr_mode = (mode_e'(mode) == MODE_RR);
    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (transfer && rr_mode),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    // Out-of-range explicit selects fall back to the last source.
    assign sel_clamp = (int'(sel) < NUM_IN) ? sel : SEL_W'(NUM_IN - 1);

    always_comb begin
        sel_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_onehot[i] = (sel_clamp == SEL_W'(i));
        end
        chosen      = rr_mode ? arb_idx : sel_clamp;
        pick_onehot = rr_mode ? (arb_any ? arb_grant : '0) : sel_onehot;
        src_data    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_onehot[i]) src_data = in_data[i*W +: W];
        end
        in_ready = (load_en && !rst) ? pick_onehot : '0;
    end

    assign transfer = |(in_ready & in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= src_data;
            out_src   <= chosen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
